// File: rtl/ariane_pkg.sv
// Core-wide types: MAC operand-sign modes and the scoreboard tag width.
package ariane_pkg;
    localparam int TRANS_ID_BITS = 3;

    typedef enum logic [1:0] {
        MAC_SS = 2'd0,
        MAC_SU = 2'd1,
        MAC_UU = 2'd2
    } mac_sign_e;

    typedef struct packed {
        mac_sign_e sign;
        logic      sat;
    } mac_mode_t;
endpackage

// File: rtl/riscv_pkg.sv
// Architectural constants shared across the core.
package riscv;
    localparam int XLEN = 32;
endpackage

// File: rtl/simd_dot_lane_mul.sv
// One SIMD lane: extend both operands by one bit according to the sign mode, then multiply signed.
module simd_dot_lane_mul
    import ariane_pkg::*;
#(
    parameter int LANE_W = 8
) (
    input  logic [LANE_W-1:0]          a_i,
    input  logic [LANE_W-1:0]          b_i,
    input  mac_sign_e                  sign_i,
    output logic signed [2*LANE_W+1:0] prod_o
);
    logic signed [LANE_W:0] a_x, b_x;

    // a is signed in SS and SU, b only in SS
    assign a_x    = $signed({(sign_i != MAC_UU) & a_i[LANE_W-1], a_i});
    assign b_x    = $signed({(sign_i == MAC_SS) & b_i[LANE_W-1], b_i});
    assign prod_o = a_x * b_x;
endmodule

// File: rtl/simd_dot_mac.sv
// Three-stage SIMD dot-product accumulate: lane products, adder tree, accumulate with optional saturation.
module simd_dot_mac
    import ariane_pkg::*;
#(
    parameter int XLEN   = riscv::XLEN,
    parameter int LANE_W = 8,
    parameter bit SAT_EN = 1'b1
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic                     mac_valid_i,
    output logic                     mac_ready_o,
    input  logic                     flush_i,
    input  mac_mode_t                mode_i,
    input  logic [XLEN-1:0]          operand_a_i,
    input  logic [XLEN-1:0]          operand_b_i,
    input  logic [XLEN-1:0]          acc_i,
    input  logic [TRANS_ID_BITS-1:0] trans_id_i,
    output logic [XLEN-1:0]          result_o,
    output logic [TRANS_ID_BITS-1:0] trans_id_o,
    output logic                     overflow_o,
    output logic                     mac_valid_o,
    input  logic                     out_ready_i
);
    localparam int N_LANES = XLEN / LANE_W;
    localparam int SUM_W   = 2*LANE_W + $clog2(N_LANES) + 1;
    localparam int PROD_W  = 2*LANE_W + 2;
    // XLEN+1 for the default config; widened when the tree sum alone exceeds XLEN
    localparam int RES_W   = ((SUM_W > XLEN) ? SUM_W : XLEN) + 1;
    localparam int STAGES  = 3;

    logic [STAGES:1] vld_pipe;
    logic            advance, accept;

    logic signed [PROD_W-1:0] prod_d [N_LANES];
    logic signed [PROD_W-1:0] prod_q [N_LANES];
    logic [XLEN-1:0]          acc1_q, acc2_q;
    logic [TRANS_ID_BITS-1:0] tid1_q, tid2_q, tid3_q;
    logic                     sat1_q, sat2_q;
    logic signed [SUM_W-1:0]  sum_d, sum_q;
    logic signed [RES_W-1:0]  wide;
    logic [XLEN-1:0]          res_d, res_q;
    logic                     ovf_d, ovf_q;

    assign advance     = out_ready_i | ~vld_pipe[STAGES];
    assign mac_ready_o = advance & ~flush_i;
    assign accept      = mac_valid_i & mac_ready_o;

    for (genvar i = 0; i < N_LANES; i++) begin : g_lane
        simd_dot_lane_mul #(.LANE_W(LANE_W)) u_mul (
            .a_i    (operand_a_i[i*LANE_W +: LANE_W]),
            .b_i    (operand_b_i[i*LANE_W +: LANE_W]),
            .sign_i (mode_i.sign),
            .prod_o (prod_d[i])
        );
    end

    always_comb begin
        sum_d = '0;
        for (int i = 0; i < N_LANES; i++) sum_d += SUM_W'(prod_q[i]);
    end

    always_comb begin
        wide  = RES_W'($signed(acc2_q)) + RES_W'(sum_q);
        ovf_d = (wide != RES_W'($signed(wide[XLEN-1:0])));
        res_d = wide[XLEN-1:0];
        if (SAT_EN && sat2_q && ovf_d)
            res_d = wide[RES_W-1] ? {1'b1, {(XLEN-1){1'b0}}} : {1'b0, {(XLEN-1){1'b1}}};
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            vld_pipe <= '0;
            for (int i = 0; i < N_LANES; i++) prod_q[i] <= '0;
            acc1_q <= '0; tid1_q <= '0; sat1_q <= 1'b0;
            sum_q  <= '0; acc2_q <= '0; tid2_q <= '0; sat2_q <= 1'b0;
            res_q  <= '0; ovf_q  <= 1'b0; tid3_q <= '0;
        end else begin
            if (flush_i)      vld_pipe <= '0;
            else if (advance) vld_pipe <= {vld_pipe[STAGES-1:1], accept};
            if (advance) begin
                for (int i = 0; i < N_LANES; i++) prod_q[i] <= prod_d[i];
                acc1_q <= acc_i;  tid1_q <= trans_id_i; sat1_q <= mode_i.sat;
                sum_q  <= sum_d;  acc2_q <= acc1_q;     tid2_q <= tid1_q; sat2_q <= sat1_q;
                res_q  <= res_d;  ovf_q  <= ovf_d;      tid3_q <= tid2_q;
            end
        end
    end

    // outputs are forced to zero when no valid result is present
    assign mac_valid_o = vld_pipe[STAGES];
    assign result_o    = vld_pipe[STAGES] ? res_q  : '0;
    assign overflow_o  = vld_pipe[STAGES] & ovf_q;
    assign trans_id_o  = vld_pipe[STAGES] ? tid3_q : '0;
endmodule

// File: tb/tb_simd_dot_mac.sv
// Self-checking bench for simd_dot_mac (XLEN=32, LANE_W=8): vector table plus stall, flush and reset sequences.
module tb_simd_dot_mac;
    import ariane_pkg::*;

    logic                     clk_i = 1'b0;
    logic                     rst_ni;
    logic                     mac_valid_i, flush_i, out_ready_i;
    mac_mode_t                mode_i;
    logic [31:0]              operand_a_i, operand_b_i, acc_i;
    logic [TRANS_ID_BITS-1:0] trans_id_i;
    logic                     mac_ready_o, overflow_o, mac_valid_o;
    logic [31:0]              result_o;
    logic [TRANS_ID_BITS-1:0] trans_id_o;

    simd_dot_mac #(.XLEN(32), .LANE_W(8), .SAT_EN(1'b1)) dut (
        .clk_i(clk_i), .rst_ni(rst_ni), .mac_valid_i(mac_valid_i), .mac_ready_o(mac_ready_o),
        .flush_i(flush_i), .mode_i(mode_i), .operand_a_i(operand_a_i), .operand_b_i(operand_b_i),
        .acc_i(acc_i), .trans_id_i(trans_id_i), .result_o(result_o), .trans_id_o(trans_id_o),
        .overflow_o(overflow_o), .mac_valid_o(mac_valid_o), .out_ready_i(out_ready_i)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        mac_mode_t   mode;
        logic [31:0] a, b, acc, res;
        logic        ovf;
    } vec_t;

    typedef struct {
        logic [31:0]              res;
        logic                     ovf;
        logic [TRANS_ID_BITS-1:0] tid;
    } exp_t;

    vec_t vec [8];
    exp_t sb_q [$];
    int   checks = 0;
    int   errors = 0;
    logic [TRANS_ID_BITS-1:0] next_tid = '0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Scoreboard: pop and compare every delivered result
    always @(negedge clk_i) begin
        if (rst_ni && mac_valid_o && out_ready_i) begin
            if (sb_q.size() == 0) begin
                checks++; errors++;
                $display("FAIL unexpected_result: got 0x%0h with no request outstanding", result_o);
            end else begin
                exp_t e;
                e = sb_q.pop_front();
                chk("result", 64'(result_o), 64'(e.res));
                chk("overflow", 64'(overflow_o), 64'(e.ovf));
                chk("trans_id", 64'(trans_id_o), 64'(e.tid));
            end
        end
    end

    // Inputs change at posedge+1; acceptance is judged from mac_ready_o at the negedge
    task automatic send(input vec_t v);
        bit done = 0;
        mac_valid_i = 1'b1; mode_i = v.mode; operand_a_i = v.a; operand_b_i = v.b;
        acc_i = v.acc; trans_id_i = next_tid;
        for (int k = 0; k < 40 && !done; k++) begin
            @(negedge clk_i);
            if (mac_ready_o) begin
                sb_q.push_back('{res: v.res, ovf: v.ovf, tid: next_tid});
                next_tid = next_tid + 1'b1;
                done = 1;
            end
            @(posedge clk_i); #1;
        end
        if (!done) begin
            checks++; errors++;
            $display("FAIL send_timeout: got ready=0 expected ready=1 within 40 cycles");
        end
        mac_valid_i = 1'b0;
    endtask

    task automatic drain();
        for (int k = 0; k < 50 && sb_q.size() != 0; k++) begin
            @(posedge clk_i); #1;
        end
        chk("drain_outstanding", 64'(sb_q.size()), 64'd0);
    endtask

    localparam mac_mode_t SS_SAT = '{sign: MAC_SS, sat: 1'b1};
    localparam mac_mode_t SS_WRP = '{sign: MAC_SS, sat: 1'b0};
    localparam mac_mode_t SU_WRP = '{sign: MAC_SU, sat: 1'b0};
    localparam mac_mode_t UU_WRP = '{sign: MAC_UU, sat: 1'b0};

    initial begin
        vec[0] = '{mode: SU_WRP, a: 32'hFF020304, b: 32'h01010101, acc: 32'h0,        res: 32'h00000008, ovf: 1'b0};
        vec[1] = '{mode: SS_WRP, a: 32'h80808080, b: 32'h80808080, acc: 32'h0,        res: 32'h00010000, ovf: 1'b0};
        vec[2] = '{mode: UU_WRP, a: 32'hFFFFFFFF, b: 32'hFFFFFFFF, acc: 32'h0,        res: 32'h0003F804, ovf: 1'b0};
        vec[3] = '{mode: SS_SAT, a: 32'h7F7F7F7F, b: 32'h7F7F7F7F, acc: 32'h7FFFFFF0, res: 32'h7FFFFFFF, ovf: 1'b1};
        vec[4] = '{mode: SS_WRP, a: 32'h7F7F7F7F, b: 32'h7F7F7F7F, acc: 32'h7FFFFFF0, res: 32'h8000FBF4, ovf: 1'b1};
        vec[5] = '{mode: SS_SAT, a: 32'h80808080, b: 32'h7F7F7F7F, acc: 32'h80000000, res: 32'h80000000, ovf: 1'b1};
        vec[6] = '{mode: SU_WRP, a: 32'h80808080, b: 32'hFFFFFFFF, acc: 32'h0,        res: 32'hFFFE0200, ovf: 1'b0};
        vec[7] = '{mode: UU_WRP, a: 32'h01020304, b: 32'h05060708, acc: 32'h10,       res: 32'h00000056, ovf: 1'b0};

        rst_ni = 1'b0; mac_valid_i = 1'b0; flush_i = 1'b0; out_ready_i = 1'b1;
        mode_i = UU_WRP; operand_a_i = '0; operand_b_i = '0; acc_i = '0; trans_id_i = '0;
        repeat (2) @(posedge clk_i);
        @(negedge clk_i);
        chk("rst_valid", 64'(mac_valid_o), 64'd0);
        chk("rst_result", 64'(result_o), 64'd0);
        chk("rst_overflow", 64'(overflow_o), 64'd0);
        chk("rst_trans_id", 64'(trans_id_o), 64'd0);
        @(posedge clk_i); #1 rst_ni = 1'b1;
        @(negedge clk_i);
        chk("rst_ready", 64'(mac_ready_o), 64'd1);
        @(posedge clk_i); #1;

        // Back-to-back table, wrap-mode saturating underflow variant included
        for (int i = 0; i < 8; i++) send(vec[i]);
        send('{mode: SS_WRP, a: 32'h80808080, b: 32'h7F7F7F7F, acc: 32'h80000000, res: 32'h7FFF0200, ovf: 1'b1});
        drain();

        // Latency: valid appears exactly at the third edge after acceptance
        send(vec[0]);
        @(negedge clk_i); chk("latency_c1", 64'(mac_valid_o), 64'd0);
        @(posedge clk_i); @(negedge clk_i); chk("latency_c2", 64'(mac_valid_o), 64'd0);
        @(posedge clk_i); @(negedge clk_i); chk("latency_c3", 64'(mac_valid_o), 64'd1);
        @(posedge clk_i); #1;
        drain();

        // Stall with three ops in flight
        send(vec[0]); send(vec[1]); send(vec[2]);
        out_ready_i = 1'b0;
        repeat (4) begin
            @(negedge clk_i);
            chk("stall_ready", 64'(mac_ready_o), 64'd0);
            chk("stall_valid", 64'(mac_valid_o), 64'd1);
            chk("stall_result", 64'(result_o), 64'(vec[0].res));
            @(posedge clk_i); #1;
        end
        out_ready_i = 1'b1;
        drain();

        // Flush two in-flight ops, then a fresh request
        send(vec[3]); send(vec[4]);
        flush_i = 1'b1;
        sb_q.delete();
        @(negedge clk_i);
        chk("flush_ready", 64'(mac_ready_o), 64'd0);
        @(posedge clk_i); #1 flush_i = 1'b0;
        @(negedge clk_i); chk("flush_valid_after", 64'(mac_valid_o), 64'd0);
        @(posedge clk_i); #1;
        send(vec[7]);
        @(negedge clk_i); chk("flush_no_stale1", 64'(mac_valid_o), 64'd0);
        @(posedge clk_i); @(negedge clk_i); chk("flush_no_stale2", 64'(mac_valid_o), 64'd0);
        @(posedge clk_i); #1;
        drain();

        // Reset with two ops in flight
        send(vec[5]); send(vec[6]);
        rst_ni = 1'b0;
        sb_q.delete();
        repeat (2) begin
            @(negedge clk_i);
            chk("midrst_valid", 64'(mac_valid_o), 64'd0);
            chk("midrst_result", 64'(result_o), 64'd0);
            @(posedge clk_i); #1;
        end
        rst_ni = 1'b1;
        repeat (6) begin
            @(negedge clk_i);
            chk("postrst_valid", 64'(mac_valid_o), 64'd0);
            chk("postrst_result", 64'(result_o), 64'd0);
            @(posedge clk_i); #1;
        end
        chk("final_outstanding", 64'(sb_q.size()), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
